phase_sync_ctrl: RTL
====================

// Module: phase_sync_ctrl
// PURPOSE
//  Acquisition/tracking controller for the rx sampling phase of the QPSK link.
//  Generates the 1-in-UPSAMPLE symbol strobe that drives the prbs and ber enables.
//  Sweeps every rx phase_in value, counts bit errors per phase and selects the phase with the fewest errors.
//  Then monitors the error rate and re-acquires on loss of lock.
//  Sits between the switch/enable logic and the prbs/rx/ber datapath; replaces the fixed i_sw phase select.
// PARAMETERS
//  UPSAMPLE     4     samples per symbol; also the number of candidate phases
//  PHASE_W      2     width of o_phase; must equal clog2(UPSAMPLE)
//  SETTLE       64    symbol strobes ignored after each phase change (rx filter flush)
//  WINDOW       1024  symbol strobes per error-measurement window
//  CNT_W        11    error counter width; must equal clog2(WINDOW+1)
//  LOSS_THRESH  32    max errors per window still considered locked
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-high
//  i_enable   in   1       run acquisition/tracking; low forces IDLE
//  i_err      in   1       error bit (sx^dx) from ber; sampled only in o_sym_stb cycles
//  o_sym_stb  out  1       one-cycle symbol strobe, period UPSAMPLE; feeds prbs/ber enable
//  o_phase    out  PHASE_W rx phase_in select
//  o_locked   out  1       phase acquired and error rate <= LOSS_THRESH
//  o_busy     out  1       FSM not in IDLE
//  o_err_cnt  out  CNT_W   error count of the last completed decision (best_err or tracking window)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; div=0; cand=0; best_err=all ones; best_phase=0.
//  Strobe: div counts 0..UPSAMPLE-1 and wraps; it runs whenever not in reset, independent of i_enable.
//   o_sym_stb <= (div==UPSAMPLE-1), so the first strobe comes on the UPSAMPLE-th edge after rst falls.
//  FSM states: IDLE, SETTLE, MEASURE, DECIDE. A mode bit selects SWEEP or TRACK.
//  IDLE: on i_enable=1 -> SETTLE in mode=SWEEP; cand=0; o_phase=0; best_err=all ones.
//  SETTLE: counts SETTLE strobes and ignores i_err, then -> MEASURE with err_acc=0 and sym_cnt=0.
//  MEASURE: on each strobe, err_acc+=i_err and sym_cnt++. After the WINDOW-th strobe (its error included) -> DECIDE.
//  DECIDE, one cycle, mode=SWEEP:
//   - If err_acc < best_err (strict, so ties keep the lower phase), set best_err=err_acc and best_phase=cand.
//   - If cand < UPSAMPLE-1: cand++, o_phase=cand+1, -> SETTLE.
//   - Else (last phase) use the updated best values:
//     - best_err <= LOSS_THRESH: o_phase=best_phase, o_err_cnt=best_err, o_locked=1, mode=TRACK, -> SETTLE.
//     - Otherwise: o_err_cnt=best_err, restart the sweep (cand=0, o_phase=0, best_err=all ones, -> SETTLE); o_locked stays 0.
//  DECIDE, one cycle, mode=TRACK: o_err_cnt=err_acc.
//   - err_acc <= LOSS_THRESH: -> MEASURE directly (no settle; phase unchanged).
//   - err_acc > LOSS_THRESH: o_locked=0, restart the sweep as above.
//  Simultaneous events: a strobe in the DECIDE cycle is ignored. Strobe spacing is >=2, so with UPSAMPLE>=2 no strobe is lost.
//  i_enable=0 in any state: IDLE on the next edge; o_locked=0; o_busy=0; o_phase and o_err_cnt hold.
//   Re-enable always restarts the sweep from phase 0.
//  rst mid-operation has the reset values above, including o_phase=0.
//  err_acc cannot overflow because CNT_W covers WINDOW; no saturation logic.
//  Sweep duration: UPSAMPLE*(SETTLE+WINDOW) strobes + UPSAMPLE DECIDE cycles.
// STRUCTURE
//  Shared package qpsk_pkg: FSM state enum, mode enum, UPSAMPLE default constant.
//  Sub-module sym_strobe_gen: div counter plus registered o_sym_stb, parameter UPSAMPLE.
//  The rest is one FSM with counters sym_cnt and err_acc and registers cand and best_*.
// TESTING  (use UPSAMPLE=4, SETTLE=4, WINDOW=16, LOSS_THRESH=2)
//  1. Hold rst 3 cycles, then release with i_enable=0.
//     -> All outputs 0; o_sym_stb high on edges 4, 8, 12...; FSM stays IDLE.
//  2. i_enable=1; i_err=1 unless o_phase==2.
//     -> o_phase steps 0,1,2,3 and then settles at 2; o_locked=1; o_err_cnt=0; sweep takes 80 strobes + 4 DECIDE cycles.
//  3. Zero errors at phases 1 and 3, errors at 0 and 2.
//     -> Lock at o_phase=1 (tie keeps the lower phase).
//  4. Locked, then inject 3 errors within one 16-strobe window.
//     -> At that DECIDE, o_err_cnt=3, o_locked=0, o_phase=0, sweep restarts.
//     -> With 2 errors instead: lock is held and o_err_cnt=2.
//  5. Exactly 5 errors per window at every phase.
//     -> Never locks; o_err_cnt=5 after each sweep; sweeps repeat; o_busy=1.
//  6. Drop i_enable mid-MEASURE.
//     -> Next edge: o_busy=0, o_locked=0, o_phase held. Re-enable restarts at phase 0.
//     -> Pulsing rst mid-sweep gives all outputs 0 on the next edge.

Source files
------------

// File: rtl/qpsk_pkg.sv
// rtl/qpsk_pkg.sv - shared types and defaults for the QPSK rx phase controller
package qpsk_pkg;

  localparam int UPSAMPLE_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DECIDE
  } sync_state_e;

  typedef enum logic {
    MODE_SWEEP,
    MODE_TRACK
  } sync_mode_e;

endpackage

// File: rtl/sym_strobe_gen.sv
// rtl/sym_strobe_gen.sv - free-running 1-in-UPSAMPLE symbol strobe
module sym_strobe_gen
  import qpsk_pkg::*;
#(
  parameter int UPSAMPLE = UPSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic sym_stb
);

  localparam int DIV_W = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(UPSAMPLE - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      sym_stb <= 1'b0;
    end else begin
      sym_stb <= (div == DIV_LAST);
      div     <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

endmodule

// File: rtl/phase_sync_ctrl.sv
// rtl/phase_sync_ctrl.sv - rx sampling-phase acquisition and lock tracking
module phase_sync_ctrl
  import qpsk_pkg::*;
#(
  parameter int UPSAMPLE    = UPSAMPLE_DEF,
  parameter int PHASE_W     = 2,
  parameter int SETTLE      = 64,
  parameter int WINDOW      = 1024,
  parameter int CNT_W       = 11,
  parameter int LOSS_THRESH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic               i_err,
  output logic               o_sym_stb,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_locked,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_err_cnt
);

  localparam int SYM_W = $clog2(((WINDOW > SETTLE) ? WINDOW : SETTLE) + 1);
  localparam logic [SYM_W-1:0]   SETTLE_LAST = SYM_W'(SETTLE - 1);
  localparam logic [SYM_W-1:0]   WINDOW_LAST = SYM_W'(WINDOW - 1);
  localparam logic [PHASE_W-1:0] CAND_LAST   = PHASE_W'(UPSAMPLE - 1);
  localparam logic [CNT_W-1:0]   THRESH      = CNT_W'(LOSS_THRESH);

  sync_state_e        state, state_nxt;
  sync_mode_e         mode, mode_nxt;
  logic [PHASE_W-1:0] cand, cand_nxt;
  logic [PHASE_W-1:0] best_phase, best_phase_nxt;
  logic [CNT_W-1:0]   best_err, best_err_nxt;
  logic [CNT_W-1:0]   err_acc, err_acc_nxt;
  logic [SYM_W-1:0]   sym_cnt, sym_cnt_nxt;
  logic [PHASE_W-1:0] phase_nxt;
  logic               locked_nxt;
  logic [CNT_W-1:0]   err_cnt_nxt;
  logic               restart;
  logic               better;
  logic [CNT_W-1:0]   dec_err;
  logic [PHASE_W-1:0] dec_phase;

  sym_strobe_gen #(
    .UPSAMPLE(UPSAMPLE)
  ) u_stb (
    .clk    (clk),
    .rst    (rst),
    .sym_stb(o_sym_stb)
  );

  assign o_busy = (state != ST_IDLE);

  // Strict compare: a tie keeps the earlier (lower) candidate phase.
  assign better    = (err_acc < best_err);
  assign dec_err   = better ? err_acc : best_err;
  assign dec_phase = better ? cand : best_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode       <= MODE_SWEEP;
      cand       <= '0;
      best_phase <= '0;
      best_err   <= '1;
      err_acc    <= '0;
      sym_cnt    <= '0;
      o_phase    <= '0;
      o_locked   <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      mode       <= mode_nxt;
      cand       <= cand_nxt;
      best_phase <= best_phase_nxt;
      best_err   <= best_err_nxt;
      err_acc    <= err_acc_nxt;
      sym_cnt    <= sym_cnt_nxt;
      o_phase    <= phase_nxt;
      o_locked   <= locked_nxt;
      o_err_cnt  <= err_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    mode_nxt       = mode;
    cand_nxt       = cand;
    best_phase_nxt = best_phase;
    best_err_nxt   = best_err;
    err_acc_nxt    = err_acc;
    sym_cnt_nxt    = sym_cnt;
    phase_nxt      = o_phase;
    locked_nxt     = o_locked;
    err_cnt_nxt    = o_err_cnt;
    restart        = 1'b0;

    if (!i_enable) begin
      state_nxt  = ST_IDLE;
      locked_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: restart = 1'b1;

        ST_SETTLE: begin
          if (o_sym_stb) begin
            if (sym_cnt == SETTLE_LAST) begin
              state_nxt   = ST_MEASURE;
              sym_cnt_nxt = '0;
              err_acc_nxt = '0;
            end else begin
              sym_cnt_nxt = sym_cnt + 1'b1;
            end
          end
        end

        ST_MEASURE: begin
          if (o_sym_stb) begin
            err_acc_nxt = err_acc + {{(CNT_W-1){1'b0}}, i_err};
            if (sym_cnt == WINDOW_LAST) begin
              state_nxt = ST_DECIDE;
            end else begin
              sym_cnt_nxt = sym_cnt + 1'b1;
            end
          end
        end

        ST_DECIDE: begin
          if (mode == MODE_SWEEP) begin
            best_err_nxt   = dec_err;
            best_phase_nxt = dec_phase;
            if (cand < CAND_LAST) begin
              cand_nxt    = cand + 1'b1;
              phase_nxt   = cand + 1'b1;
              state_nxt   = ST_SETTLE;
              sym_cnt_nxt = '0;
            end else if (dec_err <= THRESH) begin
              phase_nxt   = dec_phase;
              err_cnt_nxt = dec_err;
              locked_nxt  = 1'b1;
              mode_nxt    = MODE_TRACK;
              state_nxt   = ST_SETTLE;
              sym_cnt_nxt = '0;
            end else begin
              err_cnt_nxt = dec_err;
              restart     = 1'b1;
            end
          end else begin
            err_cnt_nxt = err_acc;
            if (err_acc <= THRESH) begin
              state_nxt   = ST_MEASURE;
              sym_cnt_nxt = '0;
              err_acc_nxt = '0;
            end else begin
              locked_nxt = 1'b0;
              restart    = 1'b1;
            end
          end
        end

        default: state_nxt = ST_IDLE;
      endcase

      if (restart) begin
        state_nxt    = ST_SETTLE;
        mode_nxt     = MODE_SWEEP;
        cand_nxt     = '0;
        phase_nxt    = '0;
        best_err_nxt = '1;
        sym_cnt_nxt  = '0;
      end
    end
  end

endmodule
